// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with shared edge/center-aligned counter, double-buffered duties and per-channel polarity
module pwm_multi #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  parameter logic [NCH-1:0] POL = '0,
  parameter int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             duty_wr,
  input  logic [CW-1:0]    duty_ch,
  input  logic [WIDTH-1:0] duty_data,
  output logic [NCH-1:0]   pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] cnt
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic dir, mode_act, boundary;
  logic [NCH-1:0] pwm_raw;
  logic [WIDTH-1:0] shadow [NCH];
  logic [WIDTH-1:0] active [NCH];
  logic [WIDTH-1:0] shadow_nxt [NCH];
  // last cycle of a period: cnt==MAX in edge mode, the down-counting zero in center mode
  always_comb boundary = en && (mode_act ? (cnt == '0 && dir) : (cnt == MAX));
  // shadow after this cycle's write; also the bypass value for a boundary load
  always_comb begin
    for (int i = 0; i < NCH; i++)
      shadow_nxt[i] = (duty_wr && duty_ch == CW'(i)) ? duty_data : shadow[i];
  end
  // shared period counter, direction, latched mode and period-start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dir <= 1'b0;
      mode_act <= 1'b0;
      period_start <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      dir <= 1'b0;
      mode_act <= mode;
      period_start <= 1'b0;
    end else begin
      period_start <= cnt == '0 && !dir;
      if (boundary)
        mode_act <= mode;
      if (!mode_act)
        cnt <= cnt + WIDTH'(1);
      else if (!dir) begin
        if (cnt == MAX)
          dir <= 1'b1;
        else
          cnt <= cnt + WIDTH'(1);
      end else begin
        if (cnt == '0)
          dir <= 1'b0;
        else
          cnt <= cnt - WIDTH'(1);
      end
    end
  end
  // duty double-buffering and per-channel compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_raw <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= shadow_nxt[i];
        active[i] <= (!en || boundary) ? shadow_nxt[i] : active[i];
        pwm_raw[i] <= en && (cnt < active[i]);
      end
    end
  end
  assign pwm_out = pwm_raw ^ POL;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed checks of pwm_multi counting, duty buffering, modes, polarity and reset
module tb_pwm_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, mode = 1'b0, duty_wr = 1'b0;
  logic [1:0] duty_ch = '0;
  logic [7:0] duty_data = '0;
  logic [3:0] pwm_out;
  logic period_start;
  logic [7:0] cnt;
  logic [3:0] pol_out;
  logic pol_ps;
  logic [7:0] pol_cnt;
  logic en3 = 1'b0, wr3 = 1'b0;
  logic [1:0] ch3 = '0;
  logic [3:0] data3 = '0;
  logic [2:0] out3;
  logic ps3;
  logic [3:0] cnt3;
  int vectors = 0, miscompares = 0;
  int hi [4];
  int hi3 [3];
  int ps;

  always #5 clk = ~clk;

  pwm_multi u_dut (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .duty_wr(duty_wr),
    .duty_ch(duty_ch), .duty_data(duty_data), .pwm_out(pwm_out), .period_start(period_start), .cnt(cnt));
  pwm_multi #(.POL(4'b1010)) u_pol (.clk(clk), .rst_n(rst_n), .en(en), .mode(1'b0), .duty_wr(1'b0),
    .duty_ch(2'd0), .duty_data(8'd0), .pwm_out(pol_out), .period_start(pol_ps), .cnt(pol_cnt));
  pwm_multi #(.WIDTH(4), .NCH(3)) u_n3 (.clk(clk), .rst_n(rst_n), .en(en3), .mode(1'b0), .duty_wr(wr3),
    .duty_ch(ch3), .duty_data(data3), .pwm_out(out3), .period_start(ps3), .cnt(cnt3));

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int ch, input int data);
    duty_ch = 2'(ch);
    duty_data = 8'(data);
    duty_wr = 1'b1;
    @(negedge clk);
    duty_wr = 1'b0;
  endtask

  task automatic wr3_do(input int ch, input int data);
    ch3 = 2'(ch);
    data3 = 4'(data);
    wr3 = 1'b1;
    @(negedge clk);
    wr3 = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    @(negedge clk);
    while (cnt != 8'(v) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_cnt_%0d", v), int'(cnt), v);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < 4; c++) hi[c] = 0;
    for (int c = 0; c < 3; c++) hi3[c] = 0;
    ps = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
      for (int c = 0; c < 3; c++) hi3[c] += int'(out3[c]);
      ps += int'(period_start);
    end
  endtask

  initial begin
    #1;
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_pol_out", int'(pol_out), 4'b1010);
    chk("rst_pol_cnt", int'(pol_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(0, 0);
    wr(1, 64);
    wr(2, 128);
    wr(3, 255);
    wr3_do(3, 15);
    wr3_do(2, 4);
    en = 1'b1;
    en3 = 1'b1;
    @(negedge clk);
    chk("start_ps", int'(period_start), 1);
    chk("start_cnt", int'(cnt), 1);
    chk("start_pwm", int'(pwm_out), 4'b1110);
    run(768);
    chk("edge_hi0", hi[0], 0);
    chk("edge_hi1", hi[1], 192);
    chk("edge_hi2", hi[2], 384);
    chk("edge_hi3", hi[3], 765);
    chk("edge_ps", ps, 3);
    chk("n3_hi0", hi3[0], 0);
    chk("n3_hi1", hi3[1], 0);
    chk("n3_hi2", hi3[2], 192);
    chk("pol_run", int'(pol_out), 4'b1010);
    wait_cnt(100);
    wr(2, 32);
    wait_cnt(128);
    chk("mid_write_old_duty", int'(pwm_out[2]), 1);
    wait_cnt(1);
    run(256);
    chk("mid_write_new_hi2", hi[2], 32);
    chk("mid_write_hi1", hi[1], 64);
    wait_cnt(255);
    wr(1, 10);
    run(256);
    chk("bypass_hi1", hi[1], 10);
    chk("bypass_hi2", hi[2], 32);
    wait_cnt(10);
    mode = 1'b1;
    wait_cnt(255);
    @(negedge clk);
    chk("mode_deferred_wrap", int'(cnt), 0);
    wait_cnt(255);
    @(negedge clk);
    chk("center_max_repeat", int'(cnt), 255);
    wait_cnt(50);
    run(512);
    chk("center_hi0", hi[0], 0);
    chk("center_hi1", hi[1], 20);
    chk("center_hi2", hi[2], 64);
    chk("center_hi3", hi[3], 510);
    chk("center_ps", ps, 1);
    chk("pol_center", int'(pol_out), 4'b1010);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_cnt", int'(cnt), 0);
    chk("en_off_pwm", int'(pwm_out), 0);
    chk("en_off_ps", int'(period_start), 0);
    en = 1'b1;
    @(negedge clk);
    chk("en_on_ps", int'(period_start), 1);
    chk("en_on_cnt", int'(cnt), 1);
    chk("en_on_pwm", int'(pwm_out), 4'b1110);
    wait_cnt(77);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", int'(cnt), 0);
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_pol", int'(pol_out), 4'b1010);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ps", int'(period_start), 1);
    chk("rst_release_cnt", int'(cnt), 1);
    chk("rst_release_pwm", int'(pwm_out), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator; successor to the team's single-channel 8-bit PWM.
- One shared period counter drives NCH channels. Each channel has its own duty compare.
- Adds configurable width, edge- or center-aligned mode, and per-channel polarity.
- Duty values are double-buffered and take effect only at period boundaries, so no glitches occur. The block sits between the control register file and the motor/LED drive pins.

Parameters:
WIDTH, 8, counter and duty width in bits; MAX = 2^WIDTH-1
NCH, 4, number of PWM channels (1..16); CW = max(1, clog2(NCH))
POL, {NCH{1'b0}}, per-channel polarity mask; bit i = 1 inverts pwm_out[i]

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable
mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at period boundary only
duty_wr  in  1  single-cycle write strobe for a duty shadow register
duty_ch  in  CW  channel index for the write
duty_data  in  WIDTH  duty value
pwm_out  out  NCH  registered PWM outputs, after polarity
period_start  out  1  one-cycle pulse marking the first cycle of each period
cnt  out  WIDTH  current counter value, for debug/ADC trigger

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, dir=up, mode_act=0.
  - All shadow and active duty registers = 0.
  - pwm_raw=0, so pwm_out=POL. period_start=0.
- en=0 (synchronous):
  - cnt forced to 0, dir=up, pwm_raw=0, period_start=0.
  - active duties copy shadow every cycle; mode_act copies mode.
  - Shadow writes still accepted.
- Edge mode:
  - cnt sequence is 0,1,...,MAX, then wraps to 0. Period = 2^WIDTH cycles.
  - Boundary = cycle with cnt==MAX.
- Center mode:
  - cnt sequence is 0..MAX up, MAX again (dir flips to down), MAX-1..0, 0 again (dir flips to up). Both endpoints repeat once.
  - Period = 2^(WIDTH+1) cycles.
  - Boundary = cycle with cnt==0 and dir==down.
- Compare:
  - pwm_raw[i] registered from (cnt < active_duty[i]). pwm_out[i] = pwm_raw[i] XOR POL[i].
  - Output lags cnt by 1 cycle.
  - High time per period: edge = duty; center = 2*duty, centered on cnt==0.
  - duty=0 gives constant low. duty=MAX gives low for exactly 1 cycle (edge) or 2 cycles (center) per period.
- Shadow write:
  - On duty_wr with duty_ch<NCH, shadow[duty_ch] <= duty_data.
  - duty_ch>=NCH is ignored, with no side effects.
- Boundary load:
  - On a boundary cycle (en=1), active[i] <= shadow[i] and mode_act <= mode.
  - New values govern the compare from the next cycle (cnt==0 of the new period).
  - If duty_wr hits channel i in the boundary cycle, duty_data bypasses directly to active[i] (and is also written to shadow).
- Mode change:
  - Takes effect only at a boundary; a mid-period change is ignored until then.
  - Switching edge to center at a boundary: next cycle cnt=0, dir=up.
- period_start:
  - Registered. High in the cycle where cnt==0 and the period begins.
  - Edge mode: every cnt==0 cycle. Center mode: the first cnt==0 cycle only (dir==up).
  - Also high in the first cycle after en rises.
- Reset mid-period: all state returns to reset values immediately; no partial-period completion.

Test Plan:
- WIDTH=8, NCH=4, edge mode: write duties 0, 64, 128, 255 to ch0..3, en=1, run 3 periods -> per 256-cycle period, high counts are 0, 64, 128, 255. period_start pulses every 256 cycles.
- Center mode, ch1 duty=64 -> high 128 of 512 cycles. The high window is symmetric around the repeated cnt==0 pair. period_start fires once per 512 cycles.
- Mid-period write of ch2=32 at cnt=100 -> current period still shows 128 high cycles, next period shows 32. A write in the cnt==MAX cycle is applied to the very next period.
- duty_ch=5 write with NCH=4 -> no shadow changes. Toggle mode at cnt=10 -> waveform unchanged until the boundary, then period switches from 256 to 512.
- POL=4'b1010, all duties 0 -> pwm_out=4'b1010 constant. After reset pwm_out=4'b1010, cnt=0.
- Assert rst_n low at cnt=77 and en low mid-period -> cnt=0 and pwm_raw=0 immediately (reset) or next cycle (en). On release, period_start pulses in the first active cycle.
